mp_add_sequencer: RTL and testbench

//  Multi-precision add sequencer: accepts one wide operand pair (A, B, carry-in).

---
 rtl/mp_add_pkg.sv | 6 +
 rtl/mp_add_sequencer_add_slice.sv | 12 +
 rtl/mp_add_sequencer.sv | 117 +++++++++++
 tb/tb_mp_add_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared state encoding and default geometry for the multi-precision add sequencer
package mp_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mpadd_state_e;
    localparam int CHUNK_W_DEF    = 16;
    localparam int NUM_CHUNKS_DEF = 4;
endpackage

// File: rtl/mp_add_sequencer_add_slice.sv
// add_slice: combinational CHUNK_W-bit adder slice with carry in and carry out
module add_slice #(
    parameter int CHUNK_W = 16
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] s,
    output logic               cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
endmodule

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: chunk-serial wide adder over one add_slice; MPADD_OVF_EN adds the signed-overflow output
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
    localparam int W         = CHUNK_W * NUM_CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
`ifdef MPADD_OVF_EN
    ,
    output logic         out_ovf
`endif
);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    mpadd_state_e                           state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic                                   carry_q, carry_d;
    logic                                   cout_q, cout_d;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CHUNK_W-1:0]                     s;
    logic                                   c;
    logic                                   last;
`ifdef MPADD_OVF_EN
    logic                                   ovf_q, ovf_d;
    assign out_ovf = ovf_q;
`endif

    add_slice #(.CHUNK_W(CHUNK_W)) u_slice (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .s   (s),
        .cout(c)
    );

    assign last      = idx_q == IDX_W'(NUM_CHUNKS - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
`ifdef MPADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                carry_d = in_cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q] = s;
                carry_d      = c;
                if (last) begin
                    state_d = DONE;
                    cout_d  = c;
`ifdef MPADD_OVF_EN
                    ovf_d   = (a_q[NUM_CHUNKS-1][CHUNK_W-1] == b_q[NUM_CHUNKS-1][CHUNK_W-1]) &&
                              (s[CHUNK_W-1] != a_q[NUM_CHUNKS-1][CHUNK_W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
`ifdef MPADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
`ifdef MPADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb_mp_add_sequencer: directed and randomized checks of mp_add_sequencer against a 65-bit arithmetic model
module tb_mp_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_sum;
    logic        out_cout;
`ifdef MPADD_OVF_EN
    logic        out_ovf;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mp_add_sequencer #(.CHUNK_W(16), .NUM_CHUNKS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef MPADD_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {64'd0, cin};
    endfunction

    // Offers one operand pair, scrambles the inputs after acceptance, and counts edges until out_valid.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, output int lat);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_sum !== 64'd0) begin failures++; $display("FAIL reset_sum got=%h want=0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", out_cout); end
`ifdef MPADD_OVF_EN
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", out_ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_chunk_carry;
        int lat;
        out_ready = 1'b1;
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d want=4", lat); end
        checks++; if (out_sum !== 64'h0000_0000_0001_0000) begin failures++; $display("FAIL carry_sum got=%h want=%h", out_sum, 64'h10000); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL carry_cout got=%b want=0", out_cout); end
        @(negedge clk);
    endtask

    task automatic test_full_ripple;
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL ripple_latency got=%0d want=4", lat); end
        checks++; if (out_sum !== 64'd0) begin failures++; $display("FAIL ripple_sum got=%h want=0", out_sum); end
        checks++; if (out_cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b want=1", out_cout); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure;
        int lat;
        logic [63:0] a, b;
        logic [64:0] exp;
        bit bad;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        exp = model(a, b, 1'b1);
        out_ready = 1'b0;
        run_op(a, b, 1'b1, lat);
        in_valid = 1'b1; in_a = 64'h1234; in_b = 64'h5678; in_cin = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL bp_hold got=%b/%b/%h want=1/0/%h", out_valid, in_ready, {out_cout, out_sum}, exp); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%b want=0/1", out_valid, in_ready); end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL bp_no_second_accept got=%b/%b want=0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        @(negedge clk);
        in_a = 64'hDEAD_BEEF_0000_FFFF; in_b = 64'h1111; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sum !== 64'd0) begin failures++; $display("FAIL rst_mid_run got=%b/%h want=0/0", out_valid, out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        run_op(64'd5, 64'd7, 1'b0, lat);
        checks++; if (lat !== 4 || out_sum !== 64'd12 || out_cout !== 1'b0) begin failures++; $display("FAIL rst_next_op got=%0d/%h/%b want=4/c/0", lat, out_sum, out_cout); end
        @(negedge clk);
    endtask

`ifdef MPADD_OVF_EN
    task automatic test_ovf;
        int lat;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++; if (out_sum !== 64'h8000_0000_0000_0000 || out_ovf !== 1'b1 || out_cout !== 1'b0) begin failures++; $display("FAIL ovf_pos got=%h/%b/%b want=8000000000000000/1/0", out_sum, out_ovf, out_cout); end
        @(negedge clk);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++; if (out_ovf !== 1'b0 || out_cout !== 1'b1) begin failures++; $display("FAIL ovf_neg got=%b/%b want=0/1", out_ovf, out_cout); end
        @(negedge clk);
    endtask
`endif

    // Inputs change every cycle; only those present when in_ready is high before an edge are accepted.
    task automatic test_streaming;
        logic [64:0] q[$];
        logic [64:0] exp;
        int got, cyc, last_acc, bad_sp, bad_res;
        got = 0; last_acc = -1; bad_sp = 0; bad_res = 0;
        out_ready = 1'b1;
        @(negedge clk);
        for (cyc = 0; cyc < 2000 && got < 200; cyc++) begin
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 65'bx;
                if ({out_cout, out_sum} !== exp) begin
                    bad_res++;
                    if (bad_res < 5) $display("FAIL stream_result got=%h want=%h", {out_cout, out_sum}, exp);
                end
                got++;
            end
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom);
            in_valid = (got + q.size()) < 200;
            if (in_ready && in_valid) begin
                q.push_back(model(in_a, in_b, in_cin));
                if (last_acc >= 0 && cyc - last_acc != 6) begin
                    bad_sp++;
                    if (bad_sp < 5) $display("FAIL stream_spacing got=%0d want=6", cyc - last_acc);
                end
                last_acc = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (got !== 200) begin failures++; $display("FAIL stream_count got=%0d want=200", got); end
        checks++; if (bad_res !== 0) begin failures++; $display("FAIL stream_results bad=%0d want=0", bad_res); end
        checks++; if (bad_sp !== 0) begin failures++; $display("FAIL stream_spacings bad=%0d want=0", bad_sp); end
    endtask

    initial begin
        test_reset;
        test_chunk_carry;
        test_full_ripple;
        test_back_pressure;
        test_reset_mid_run;
`ifdef MPADD_OVF_EN
        test_ovf;
`endif
        test_streaming;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
